// File: rtl/hist_chan_sched.sv
// ---------------------------------------------------------------------------
// hist_chan_sched
//
// Schedules histogram acquisition across four colour channels (R, G, B, Y).
// The block selects a channel, accumulates FRAMES_PER_CHAN frames on it, then
// asks the readout engine to drain that histogram. In auto mode the channels
// rotate R->G->B->Y; in manual mode the next channel comes from manual_sel.
//
// Parameters
//   FRAMES_PER_CHAN  frames accumulated per channel before readout (1..255)
//
// Ports
//   clk             in   rising-edge clock
//   reset_n         in   asynchronous active-low reset
//   en              in   scheduler enable; dropping it mid-ACQ aborts to IDLE
//   auto_mode       in   1 = rotate channels, 0 = follow manual_sel
//   manual_sel[1:0] in   manual channel code (0=R 1=G 2=B 3=Y)
//   start_frame     in   frame-start pulse (also seen by the channel selector)
//   frame_end_hist  in   frame-end pulse from the channel selector
//   rd_done         in   readout-complete pulse from the readout engine
//   clr_ovr         in   clears the sticky overrun flag
//   hist_switch[3:0]out  one-hot channel select (bit0=R .. bit3=Y)
//   busy            out  high while acquiring or reading
//   rd_req          out  readout request level
//   rd_chan[1:0]    out  channel code of the histogram being read
//   overrun         out  sticky: a frame start was dropped during READ
// ---------------------------------------------------------------------------
module hist_chan_sched #(
  parameter int unsigned FRAMES_PER_CHAN = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       auto_mode,
  input  logic [1:0] manual_sel,
  input  logic       start_frame,
  input  logic       frame_end_hist,
  input  logic       rd_done,
  input  logic       clr_ovr,
  output logic [3:0] hist_switch,
  output logic       busy,
  output logic       rd_req,
  output logic [1:0] rd_chan,
  output logic       overrun
);

  localparam logic [7:0] FRAMES_LAST = 8'(FRAMES_PER_CHAN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    READ = 2'd2
  } state_t;

  state_t     state_q;
  logic [1:0] acq_chan_q;
  logic [7:0] frame_cnt_q;
  logic [3:0] hist_switch_q;
  logic       busy_q;
  logic       rd_req_q;
  logic [1:0] rd_chan_q;
  logic       overrun_q;

  logic [7:0] frame_cnt_d;
  logic [3:0] next_switch_d;
  logic       drop_d;

  function automatic logic [3:0] chan_onehot(input logic [1:0] code);
    logic [3:0] oh;
    oh = 4'b0000;
    oh[code] = 1'b1;
    return oh;
  endfunction

  // hist_switch is always one-hot, so a priority encode is exact.
  function automatic logic [1:0] chan_code(input logic [3:0] oh);
    logic [1:0] code;
    code = 2'd0;
    if (oh[1]) code = 2'd1;
    if (oh[2]) code = 2'd2;
    if (oh[3]) code = 2'd3;
    return code;
  endfunction

  always_comb begin
    frame_cnt_d   = frame_cnt_q + 8'd1;
    // Rotating the one-hot word left gives R->G->B->Y->R with the wrap built in.
    next_switch_d = auto_mode ? {hist_switch_q[2:0], hist_switch_q[3]}
                              : chan_onehot(manual_sel);
    // A frame start while the histogram is being drained cannot be serviced.
    drop_d        = (state_q == READ) && start_frame;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      acq_chan_q    <= 2'd0;
      frame_cnt_q   <= 8'd0;
      hist_switch_q <= 4'b0001;
      busy_q        <= 1'b0;
      rd_req_q      <= 1'b0;
      rd_chan_q     <= 2'd0;
      overrun_q     <= 1'b0;
    end else begin
      // Setting wins over clearing so a drop coinciding with clr_ovr is not lost.
      if (drop_d)       overrun_q <= 1'b1;
      else if (clr_ovr) overrun_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (start_frame && en) begin
            state_q     <= ACQ;
            acq_chan_q  <= chan_code(hist_switch_q);
            frame_cnt_q <= 8'd0;
            busy_q      <= 1'b1;
            // hist_switch is frozen on the start cycle: the selector latches it
            // on this same pulse, so it must not move underneath that latch.
          end else if (!auto_mode) begin
            hist_switch_q <= chan_onehot(manual_sel);
          end
        end
        ACQ: begin
          if (!en) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (frame_end_hist) begin
            frame_cnt_q <= frame_cnt_d;
            if (frame_cnt_d == FRAMES_LAST) begin
              state_q   <= READ;
              rd_req_q  <= 1'b1;
              rd_chan_q <= acq_chan_q;
            end
          end
        end
        READ: begin
          if (rd_done) begin
            state_q       <= IDLE;
            rd_req_q      <= 1'b0;
            busy_q        <= 1'b0;
            hist_switch_q <= next_switch_d;
          end
        end
        default: begin
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          rd_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign hist_switch = hist_switch_q;
  assign busy        = busy_q;
  assign rd_req      = rd_req_q;
  assign rd_chan     = rd_chan_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_hist_chan_sched.sv
module tb_hist_chan_sched;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b0;
  logic       auto_mode = 1'b1;
  logic [1:0] manual_sel = 2'd0;
  logic       start_frame = 1'b0;
  logic       frame_end_hist = 1'b0;
  logic       rd_done = 1'b0;
  logic       clr_ovr = 1'b0;

  logic [3:0] hs1, hs3;
  logic       busy1, busy3, rdreq1, rdreq3, ovr1, ovr3;
  logic [1:0] rdch1, rdch3;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  hist_chan_sched #(.FRAMES_PER_CHAN(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .en(en), .auto_mode(auto_mode),
    .manual_sel(manual_sel), .start_frame(start_frame),
    .frame_end_hist(frame_end_hist), .rd_done(rd_done), .clr_ovr(clr_ovr),
    .hist_switch(hs1), .busy(busy1), .rd_req(rdreq1), .rd_chan(rdch1),
    .overrun(ovr1)
  );

  hist_chan_sched #(.FRAMES_PER_CHAN(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .en(en), .auto_mode(auto_mode),
    .manual_sel(manual_sel), .start_frame(start_frame),
    .frame_end_hist(frame_end_hist), .rd_done(rd_done), .clr_ovr(clr_ovr),
    .hist_switch(hs3), .busy(busy3), .rd_req(rdreq3), .rd_chan(rdch3),
    .overrun(ovr3)
  );

  // Advance one clock; outputs are then sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start_frame = 0; frame_end_hist = 0; rd_done = 0; clr_ovr = 0;
    @(negedge clk);
    reset_n = 0;
    tick(); tick();
    @(negedge clk);
    reset_n = 1;
    tick();
  endtask

  task automatic test_reset();
    en = 1; auto_mode = 1;
    @(negedge clk);
    #2 reset_n = 0;
    #1;
    total++; if (hs1 !== 4'b0001) begin bad++; $display("FAIL reset_hist act=%b exp=0001", hs1); end
    total++; if ({busy1, rdreq1, ovr1, rdch1} !== 5'b0) begin bad++; $display("FAIL reset_outs act=%b exp=00000", {busy1, rdreq1, ovr1, rdch1}); end
    total++; if ({busy3, rdreq3, ovr3, hs3} !== 7'b0000001) begin bad++; $display("FAIL reset_outs3 act=%b exp=0000001", {busy3, rdreq3, ovr3, hs3}); end
    @(negedge clk);
    reset_n = 1;
    tick();
  endtask

  task automatic test_auto_rotation();
    logic [3:0] exp_hs;
    do_reset();
    en = 1; auto_mode = 1;
    for (int i = 0; i < 4; i++) begin
      exp_hs = 4'b0001 << i;
      total++; if (hs1 !== exp_hs) begin bad++; $display("FAIL rot_hist[%0d] act=%b exp=%b", i, hs1, exp_hs); end
      start_frame = 1; tick(); start_frame = 0;
      total++; if ({busy1, rdreq1} !== 2'b10) begin bad++; $display("FAIL rot_acq[%0d] busy/rd_req act=%b exp=10", i, {busy1, rdreq1}); end
      frame_end_hist = 1; tick(); frame_end_hist = 0;
      total++; if (rdreq1 !== 1'b1 || rdch1 !== 2'(i)) begin bad++; $display("FAIL rot_read[%0d] rd_req=%b rd_chan=%0d exp 1/%0d", i, rdreq1, rdch1, i); end
      tick();
      total++; if (rdreq1 !== 1'b1 || hs1 !== exp_hs) begin bad++; $display("FAIL rot_hold[%0d] rd_req=%b hist=%b exp 1/%b", i, rdreq1, hs1, exp_hs); end
      rd_done = 1; tick(); rd_done = 0;
      exp_hs = 4'b0001 << ((i + 1) % 4);
      total++; if ({busy1, rdreq1} !== 2'b00 || hs1 !== exp_hs) begin bad++; $display("FAIL rot_exit[%0d] busy/rd_req=%b hist=%b exp 00/%b", i, {busy1, rdreq1}, hs1, exp_hs); end
    end
    total++; if (hs1 !== 4'b0001) begin bad++; $display("FAIL rot_wrap act=%b exp=0001", hs1); end
  endtask

  task automatic test_multi_frame();
    do_reset();
    en = 1; auto_mode = 1;
    start_frame = 1; tick(); start_frame = 0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      total++; if (rdreq3 !== 1'b0) begin bad++; $display("FAIL multi_gap[%0d] rd_req act=%b exp=0", k, rdreq3); end
      frame_end_hist = 1; tick(); frame_end_hist = 0;
      total++; if (rdreq3 !== (k == 3)) begin bad++; $display("FAIL multi_fe[%0d] rd_req act=%b exp=%0d", k, rdreq3, (k == 3)); end
    end
    total++; if (rdch3 !== 2'd0 || busy3 !== 1'b1) begin bad++; $display("FAIL multi_chan rd_chan=%0d busy=%b exp 0/1", rdch3, busy3); end
    rd_done = 1; tick(); rd_done = 0;
    total++; if ({busy3, rdreq3, hs3} !== 6'b000010) begin bad++; $display("FAIL multi_exit act=%b exp=000010", {busy3, rdreq3, hs3}); end
  endtask

  task automatic test_overrun();
    do_reset();
    en = 1; auto_mode = 1;
    start_frame = 1; tick(); start_frame = 0;
    frame_end_hist = 1; tick(); frame_end_hist = 0;
    start_frame = 1; tick(); start_frame = 0;
    total++; if ({ovr1, rdreq1, busy1, hs1} !== 7'b1110001) begin bad++; $display("FAIL ovr_in_read act=%b exp=1110001", {ovr1, rdreq1, busy1, hs1}); end
    tick();
    total++; if (ovr1 !== 1'b1) begin bad++; $display("FAIL ovr_sticky act=%b exp=1", ovr1); end
    clr_ovr = 1; tick(); clr_ovr = 0;
    total++; if (ovr1 !== 1'b0) begin bad++; $display("FAIL ovr_clear act=%b exp=0", ovr1); end
    start_frame = 1; rd_done = 1; tick(); start_frame = 0; rd_done = 0;
    total++; if ({ovr1, rdreq1, busy1, hs1} !== 7'b1000010) begin bad++; $display("FAIL ovr_with_done act=%b exp=1000010", {ovr1, rdreq1, busy1, hs1}); end
    tick();
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL ovr_dropped busy act=%b exp=0", busy1); end
    start_frame = 1; tick(); start_frame = 0;
    frame_end_hist = 1; tick(); frame_end_hist = 0;
    total++; if ({ovr1, rdreq1, rdch1} !== 4'b1101) begin bad++; $display("FAIL ovr_second_read act=%b exp=1101", {ovr1, rdreq1, rdch1}); end
    clr_ovr = 1; start_frame = 1; tick(); start_frame = 0; clr_ovr = 0;
    total++; if (ovr1 !== 1'b1) begin bad++; $display("FAIL ovr_set_wins act=%b exp=1", ovr1); end
    clr_ovr = 1; tick(); clr_ovr = 0;
    total++; if (ovr1 !== 1'b0) begin bad++; $display("FAIL ovr_clear2 act=%b exp=0", ovr1); end
    rd_done = 1; tick(); rd_done = 0;
    total++; if ({busy1, rdreq1, hs1} !== 6'b000100) begin bad++; $display("FAIL ovr_exit act=%b exp=000100", {busy1, rdreq1, hs1}); end
  endtask

  task automatic test_manual_abort();
    do_reset();
    en = 1; auto_mode = 0; manual_sel = 2'd2;
    tick();
    total++; if (hs1 !== 4'b0100) begin bad++; $display("FAIL man_sel2 act=%b exp=0100", hs1); end
    manual_sel = 2'd1; tick();
    total++; if (hs1 !== 4'b0010) begin bad++; $display("FAIL man_track act=%b exp=0010", hs1); end
    manual_sel = 2'd2; tick();
    start_frame = 1; tick(); start_frame = 0;
    total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL man_acq busy act=%b exp=1", busy1); end
    manual_sel = 2'd3; tick();
    total++; if (hs1 !== 4'b0100) begin bad++; $display("FAIL man_acq_hold act=%b exp=0100", hs1); end
    manual_sel = 2'd2; en = 0; tick();
    total++; if ({busy1, rdreq1, hs1} !== 6'b000100) begin bad++; $display("FAIL man_abort act=%b exp=000100", {busy1, rdreq1, hs1}); end
    frame_end_hist = 1; tick(); frame_end_hist = 0;
    tick();
    total++; if ({busy1, rdreq1, hs1} !== 6'b000100) begin bad++; $display("FAIL man_abort_idle act=%b exp=000100", {busy1, rdreq1, hs1}); end
    // Manual next-channel: manual_sel seen in the rd_done cycle decides.
    en = 1;
    start_frame = 1; tick(); start_frame = 0;
    frame_end_hist = 1; tick(); frame_end_hist = 0;
    total++; if (rdreq1 !== 1'b1 || rdch1 !== 2'd2) begin bad++; $display("FAIL man_read rd_req=%b rd_chan=%0d exp 1/2", rdreq1, rdch1); end
    manual_sel = 2'd3; rd_done = 1; tick(); rd_done = 0;
    total++; if (hs1 !== 4'b1000 || busy1 !== 1'b0) begin bad++; $display("FAIL man_next hist=%b busy=%b exp 1000/0", hs1, busy1); end
    auto_mode = 1;
  endtask

  task automatic test_ignored_inputs();
    do_reset();
    auto_mode = 1; en = 0;
    start_frame = 1; tick(); start_frame = 0;
    total++; if ({busy1, ovr1} !== 2'b00) begin bad++; $display("FAIL ign_start_en0 busy/ovr act=%b exp=00", {busy1, ovr1}); end
    en = 1; rd_done = 1; tick(); rd_done = 0;
    total++; if ({busy1, rdreq1, hs1} !== 6'b000001) begin bad++; $display("FAIL ign_rd_done_idle act=%b exp=000001", {busy1, rdreq1, hs1}); end
    start_frame = 1; tick(); start_frame = 0;
    rd_done = 1; tick(); rd_done = 0;
    total++; if ({busy1, rdreq1} !== 2'b10) begin bad++; $display("FAIL ign_rd_done_acq act=%b exp=10", {busy1, rdreq1}); end
    start_frame = 1; tick(); start_frame = 0;
    total++; if ({busy1, rdreq1, ovr1, hs1} !== 7'b1000001) begin bad++; $display("FAIL ign_start_acq act=%b exp=1000001", {busy1, rdreq1, ovr1, hs1}); end
    en = 0; tick(); en = 1;
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    en = 1; auto_mode = 1;
    start_frame = 1; tick(); start_frame = 0;
    frame_end_hist = 1; tick(); frame_end_hist = 0;
    rd_done = 1; tick(); rd_done = 0;
    start_frame = 1; tick(); start_frame = 0;
    frame_end_hist = 1; tick(); frame_end_hist = 0;
    total++; if (rdreq1 !== 1'b1 || rdch1 !== 2'd1 || hs1 !== 4'b0010) begin bad++; $display("FAIL rmr_pre rd_req=%b rd_chan=%0d hist=%b exp 1/1/0010", rdreq1, rdch1, hs1); end
    #2 reset_n = 0;
    #1;
    total++; if ({busy1, rdreq1, ovr1, rdch1, hs1} !== 9'b000000001) begin bad++; $display("FAIL rmr_async act=%b exp=000000001", {busy1, rdreq1, ovr1, rdch1, hs1}); end
    @(negedge clk);
    reset_n = 1;
    rd_done = 1; tick(); rd_done = 0;
    total++; if ({busy1, rdreq1, hs1} !== 6'b000001) begin bad++; $display("FAIL rmr_rd_done_ignored act=%b exp=000001", {busy1, rdreq1, hs1}); end
    start_frame = 1; tick(); start_frame = 0;
    frame_end_hist = 1; tick(); frame_end_hist = 0;
    total++; if (rdreq1 !== 1'b1 || rdch1 !== 2'd0) begin bad++; $display("FAIL rmr_acq_on_r rd_req=%b rd_chan=%0d exp 1/0", rdreq1, rdch1); end
  endtask

  initial begin
    test_reset();
    test_auto_rotation();
    test_multi_frame();
    test_overrun();
    test_manual_abort();
    test_ignored_inputs();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hist_chan_sched.md
HIST_CHAN_SCHED -- requirements
Module: hist_chan_sched

Interface
REQ-001 Parameter: FRAMES_PER_CHAN, default 1, frames accumulated per channel before readout; legal range 1..255.
REQ-002 clk  input  1  clock; all logic SHALL be rising-edge clocked.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 en  input  1  scheduler enable.
REQ-005 auto_mode  input  1  1 = rotate channels automatically, 0 = use manual_sel.
REQ-006 manual_sel  input  2  channel in manual mode: 0=R, 1=G, 2=B, 3=Y.
REQ-007 start_frame  input  1  one-cycle frame-start pulse, same pulse seen by the channel selector.
REQ-008 frame_end_hist  input  1  one-cycle frame-end pulse from the channel selector.
REQ-009 rd_done  input  1  one-cycle pulse from the histogram readout engine when readout completes.
REQ-010 clr_ovr  input  1  clears the overrun flag.
REQ-011 hist_switch  output  4  one-hot channel select to the selector: bit0=R, bit1=G, bit2=B, bit3=Y.
REQ-012 busy  output  1  high in ACQ and READ.
REQ-013 rd_req  output  1  readout request, level signal.
REQ-014 rd_chan  output  2  channel code of the histogram being read.
REQ-015 overrun  output  1  sticky flag: a frame start was dropped.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ACQ and READ. All outputs SHALL be registered.
REQ-017 IDLE: start_frame with en=1 SHALL do the following:
- go to ACQ;
- latch the current channel code into acq_chan;
- clear the frame counter;
- set busy=1 on the next cycle.
REQ-018 IDLE: start_frame with en=0 SHALL be ignored and SHALL NOT set overrun.
REQ-019 ACQ: each frame_end_hist pulse SHALL increment the 8-bit frame counter.
REQ-020 ACQ: when the count reaches FRAMES_PER_CHAN, the FSM SHALL go to READ, with rd_req=1 and rd_chan=acq_chan on the next cycle.
REQ-021 ACQ: start_frame SHALL NOT change state or hist_switch.
REQ-022 ACQ: en falling to 0 SHALL return the FSM to IDLE on the next cycle, with busy=0 and no rd_req. hist_switch SHALL be unchanged.
REQ-023 READ: rd_req SHALL stay high until rd_done is seen. The cycle after rd_done, the FSM SHALL:
- go to IDLE;
- drop rd_req and busy;
- load hist_switch with the next channel.
REQ-024 Next-channel rule:
- auto_mode=1: R->G->B->Y->R, wrapping from Y to R;
- auto_mode=0: channel = manual_sel sampled in the rd_done cycle.
REQ-025 In IDLE, hist_switch SHALL track manual_sel every cycle while auto_mode=0. It SHALL hold its value while auto_mode=1.
REQ-026 hist_switch SHALL change only in IDLE or on READ exit. It SHALL never change in a cycle where the selector could latch a mid-acquisition value.
REQ-027 start_frame in READ, including the same cycle as rd_done, SHALL be dropped and SHALL set overrun=1.
REQ-028 frame_end_hist outside ACQ SHALL be ignored.
REQ-029 rd_done outside READ SHALL be ignored.
REQ-030 overrun SHALL clear on clr_ovr. If clr_ovr and a new drop occur in the same cycle, set SHALL win.
REQ-031 hist_switch SHALL always be exactly one-hot.

Reset
REQ-032 On reset_n=0, the block SHALL immediately (asynchronously) set:
- state=IDLE;
- hist_switch=4'b0001;
- rd_chan=0;
- busy=0, rd_req=0, overrun=0;
- frame counter=0.
REQ-033 Reset asserted mid-ACQ or mid-READ SHALL abort with no rd_req pulse after release. The first start_frame after release SHALL start acquisition on channel R when auto_mode=1.

Verification
REQ-034 Auto rotation: auto_mode=1, en=1, FRAMES_PER_CHAN=1, four start/frame_end/rd_done cycles -> rd_chan sequence 0,1,2,3 and hist_switch sequence 0001,0010,0100,1000, then back to 0001.
REQ-035 Multi-frame: FRAMES_PER_CHAN=3, start_frame then three frame_end_hist pulses -> rd_req rises exactly one cycle after the third pulse, not after the first or second.
REQ-036 Overrun: start_frame in READ, and separately start_frame in the same cycle as rd_done -> both dropped, overrun=1 sticky until clr_ovr, state reaches IDLE after rd_done.
REQ-037 Manual/abort: auto_mode=0, manual_sel=2 -> hist_switch=0100 in IDLE. en=0 during ACQ -> IDLE next cycle, rd_req never asserted, hist_switch remains 0100.
REQ-038 Reset mid-READ: rd_req=1, then reset_n pulsed low -> all outputs immediately at reset values. A later rd_done is ignored. The next start_frame acquires on R.
